// File: rtl/div_ctrl_pkg.sv
// Shared types and helpers for the divide sequencer and its companion controllers.
package div_ctrl_pkg;

  localparam int BITS_DEF = 32;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Two's complement negation modulo 2^BITS_DEF.
  function automatic logic [BITS_DEF-1:0] negate(input logic [BITS_DEF-1:0] v);
    return -v;
  endfunction

  // |v| for signed operands, raw value otherwise; |min| wraps to min.
  function automatic logic [BITS_DEF-1:0] magnitude(input logic [BITS_DEF-1:0] v,
                                                    input logic is_signed);
    return (is_signed && v[BITS_DEF-1]) ? negate(v) : v;
  endfunction

  // Divider latency is the number of register stages enabled in its stage mask.
  function automatic int unsigned stage_popcount(input logic [31:0] mask);
    int unsigned cnt;
    cnt = 0;
    for (int i = 0; i < 32; i++) begin
      if (mask[i]) cnt++;
    end
    return cnt;
  endfunction

endpackage

// File: rtl/div_ctrl_if.sv
// Execute-stage request/HI-LO bus plus the divider datapath hookup.
interface div_ctrl_if
  import div_ctrl_pkg::*;
#(
  parameter int BITS = BITS_DEF
) ();

  logic            start;
  logic            is_signed;
  logic [BITS-1:0] op_a;
  logic [BITS-1:0] op_b;
  logic            hi_we;
  logic            lo_we;
  logic [BITS-1:0] wr_data;
  logic            busy;
  logic            done;
  logic            div_by_zero;
  logic [BITS-1:0] hi_out;
  logic [BITS-1:0] lo_out;
  logic [BITS-1:0] dv_dividend;
  logic [BITS-1:0] dv_divisor;
  logic            dv_valid;
  logic [BITS-1:0] dv_quotient;
  logic [BITS-1:0] dv_remainder;

  modport master (
    output start, is_signed, op_a, op_b, hi_we, lo_we, wr_data,
    output dv_quotient, dv_remainder,
    input  busy, done, div_by_zero, hi_out, lo_out,
    input  dv_dividend, dv_divisor, dv_valid
  );

  modport slave (
    input  start, is_signed, op_a, op_b, hi_we, lo_we, wr_data,
    input  dv_quotient, dv_remainder,
    output busy, done, div_by_zero, hi_out, lo_out,
    output dv_dividend, dv_divisor, dv_valid
  );

endinterface

// File: rtl/div_sign_fix.sv
// Restores result signs after an unsigned divide/multiply core.
module div_sign_fix
  import div_ctrl_pkg::*;
#(
  parameter int BITS = BITS_DEF
) (
  input  logic [BITS-1:0] i_q,
  input  logic [BITS-1:0] i_r,
  input  logic            i_neg_q,
  input  logic            i_neg_r,
  output logic [BITS-1:0] o_q,
  output logic [BITS-1:0] o_r
);

  assign o_q = i_neg_q ? negate(i_q) : i_q;
  assign o_r = i_neg_r ? negate(i_r) : i_r;

endmodule

// File: rtl/div_ctrl.sv
// DIV/DIVU sequencer: feeds the divider with magnitudes, waits out its
// latency, sign-corrects the result and owns architectural HI/LO.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int BITS    = BITS_DEF,
  parameter int LATENCY = 0,
  parameter int CNT_W   = 6
) (
  input  logic     clock,
  input  logic     reset,
  div_ctrl_if.slave bus
);

  state_t            r_state, w_next;
  logic [CNT_W-1:0]  r_cnt;
  logic [BITS-1:0]   r_mag_a, r_mag_b, r_hi, r_lo;
  logic              r_neg_q, r_neg_r, r_dbz;
  logic              w_accept, w_finish, w_op_b_zero;
  logic [BITS-1:0]   w_q_fix, w_r_fix;

  assign w_accept    = bus.start && (r_state != S_WAIT);
  assign w_finish    = (r_state == S_WAIT) && (r_cnt == '0);
  assign w_op_b_zero = (bus.op_b == '0);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) w_next = w_op_b_zero ? S_DONE : S_WAIT;
        else           w_next = S_IDLE;
      end
      S_WAIT:  if (r_cnt == '0) w_next = S_DONE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  div_sign_fix #(.BITS(BITS)) u_sign_fix (
    .i_q     (bus.dv_quotient),
    .i_r     (bus.dv_remainder),
    .i_neg_q (r_neg_q),
    .i_neg_r (r_neg_r),
    .o_q     (w_q_fix),
    .o_r     (w_r_fix)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_cnt   <= '0;
      r_mag_a <= '0;
      r_mag_b <= '0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_dbz   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
    end else begin
      if (w_accept) begin
        r_dbz <= w_op_b_zero;
        if (!w_op_b_zero) begin
          r_mag_a <= magnitude(bus.op_a, bus.is_signed);
          r_mag_b <= magnitude(bus.op_b, bus.is_signed);
          r_neg_q <= bus.is_signed && (bus.op_a[BITS-1] ^ bus.op_b[BITS-1]);
          r_neg_r <= bus.is_signed && bus.op_a[BITS-1];
          r_cnt   <= CNT_W'(LATENCY);
        end
      end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
        r_cnt <= r_cnt - CNT_W'(1);
      end

      // An accepted start drops any MTHI/MTLO in the same cycle.
      if (w_finish) begin
        r_lo <= w_q_fix;
        r_hi <= w_r_fix;
      end else if (!w_accept && (r_state != S_WAIT)) begin
        if (bus.hi_we) r_hi <= bus.wr_data;
        if (bus.lo_we) r_lo <= bus.wr_data;
      end
    end
  end

  assign bus.busy        = (r_state == S_WAIT);
  assign bus.done        = (r_state == S_DONE);
  assign bus.div_by_zero = (r_state == S_DONE) && r_dbz;
  assign bus.hi_out      = r_hi;
  assign bus.lo_out      = r_lo;
  assign bus.dv_dividend = r_mag_a;
  assign bus.dv_divisor  = r_mag_b;
  assign bus.dv_valid    = (r_state == S_WAIT) && (r_cnt == CNT_W'(LATENCY));

endmodule

// File: tb/tb_div_ctrl.sv
// Directed bench for div_ctrl at LATENCY 0 and 4, each with a divider model beside it.
module tb_div_ctrl;
  import div_ctrl_pkg::*;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  div_ctrl_if #(.BITS(32)) bus0 ();
  div_ctrl_if #(.BITS(32)) bus4 ();

  div_ctrl #(.BITS(32), .LATENCY(0), .CNT_W(6)) u_dut0 (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus0)
  );

  div_ctrl #(.BITS(32), .LATENCY(4), .CNT_W(6)) u_dut4 (
    .clock (clk),
    .reset (rst_n),
    .bus   (bus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational divider for the LATENCY=0 instance.
  assign bus0.dv_quotient  = (bus0.dv_divisor == 0) ? 32'd0 : bus0.dv_dividend / bus0.dv_divisor;
  assign bus0.dv_remainder = (bus0.dv_divisor == 0) ? 32'd0 : bus0.dv_dividend % bus0.dv_divisor;

  // Four-stage divider for the LATENCY=4 instance.
  logic [31:0] q_pipe [4];
  logic [31:0] r_pipe [4];
  always @(posedge clk) begin
    q_pipe[0] <= (bus4.dv_divisor == 0) ? 32'd0 : bus4.dv_dividend / bus4.dv_divisor;
    r_pipe[0] <= (bus4.dv_divisor == 0) ? 32'd0 : bus4.dv_dividend % bus4.dv_divisor;
    for (int i = 1; i < 4; i++) begin
      q_pipe[i] <= q_pipe[i-1];
      r_pipe[i] <= r_pipe[i-1];
    end
  end
  assign bus4.dv_quotient  = q_pipe[3];
  assign bus4.dv_remainder = r_pipe[3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    bus0.start = 0; bus0.is_signed = 0; bus0.op_a = 0; bus0.op_b = 0;
    bus0.hi_we = 0; bus0.lo_we = 0; bus0.wr_data = 0;
    bus4.start = 0; bus4.is_signed = 0; bus4.op_a = 0; bus4.op_b = 0;
    bus4.hi_we = 0; bus4.lo_we = 0; bus4.wr_data = 0;

    // Reset state
    #12;
    check("rst busy0", 32'(bus0.busy), 32'd0);
    check("rst done0", 32'(bus0.done), 32'd0);
    check("rst hi0", bus0.hi_out, 32'd0);
    check("rst lo0", bus0.lo_out, 32'd0);
    check("rst dv_valid4", 32'(bus4.dv_valid), 32'd0);
    check("rst dv_dividend4", bus4.dv_dividend, 32'd0);
    rst_n = 1'b1;
    ticks(2);

    // DIVU 100/7, LATENCY=0
    bus0.start = 1; bus0.is_signed = 0; bus0.op_a = 32'd100; bus0.op_b = 32'd7;
    ticks(1);
    bus0.start = 0;
    check("divu busy N+1", 32'(bus0.busy), 32'd1);
    check("divu dv_valid N+1", 32'(bus0.dv_valid), 32'd1);
    check("divu dv_dividend", bus0.dv_dividend, 32'd100);
    check("divu dv_divisor", bus0.dv_divisor, 32'd7);
    check("divu done N+1", 32'(bus0.done), 32'd0);
    ticks(1);
    check("divu done N+2", 32'(bus0.done), 32'd1);
    check("divu busy N+2", 32'(bus0.busy), 32'd0);
    check("divu lo", bus0.lo_out, 32'd14);
    check("divu hi", bus0.hi_out, 32'd2);
    check("divu dbz", 32'(bus0.div_by_zero), 32'd0);
    ticks(1);
    check("divu done clears", 32'(bus0.done), 32'd0);

    // DIV -7/2, LATENCY=4
    bus4.start = 1; bus4.is_signed = 1; bus4.op_a = 32'hFFFF_FFF9; bus4.op_b = 32'd2;
    ticks(1);
    bus4.start = 0;
    check("div dv_valid N+1", 32'(bus4.dv_valid), 32'd1);
    check("div dv_dividend mag", bus4.dv_dividend, 32'd7);
    check("div dv_divisor mag", bus4.dv_divisor, 32'd2);
    ticks(1);
    check("div dv_valid N+2", 32'(bus4.dv_valid), 32'd0);
    check("div dividend held", bus4.dv_dividend, 32'd7);
    ticks(3);
    check("div busy N+5", 32'(bus4.busy), 32'd1);
    check("div done N+5", 32'(bus4.done), 32'd0);
    ticks(1);
    check("div done N+6", 32'(bus4.done), 32'd1);
    check("div busy N+6", 32'(bus4.busy), 32'd0);
    check("div lo", bus4.lo_out, 32'hFFFF_FFFD);
    check("div hi", bus4.hi_out, 32'hFFFF_FFFF);
    ticks(1);

    // Divide by zero with preloaded HI/LO
    bus0.hi_we = 1; bus0.wr_data = 32'h11;
    ticks(1);
    bus0.hi_we = 0; bus0.lo_we = 1; bus0.wr_data = 32'h22;
    ticks(1);
    bus0.lo_we = 0;
    check("mthi", bus0.hi_out, 32'h11);
    check("mtlo", bus0.lo_out, 32'h22);
    bus0.start = 1; bus0.is_signed = 1; bus0.op_a = 32'd5; bus0.op_b = 32'd0;
    ticks(1);
    bus0.start = 0;
    check("dbz done N+1", 32'(bus0.done), 32'd1);
    check("dbz flag", 32'(bus0.div_by_zero), 32'd1);
    check("dbz busy", 32'(bus0.busy), 32'd0);
    check("dbz hi kept", bus0.hi_out, 32'h11);
    check("dbz lo kept", bus0.lo_out, 32'h22);
    ticks(1);
    check("dbz flag clears", 32'(bus0.div_by_zero), 32'd0);

    // Overflow, then back-to-back start in the DONE cycle
    bus4.start = 1; bus4.is_signed = 1; bus4.op_a = 32'h8000_0000; bus4.op_b = 32'hFFFF_FFFF;
    ticks(1);
    bus4.start = 0;
    ticks(5);
    check("ovf done", 32'(bus4.done), 32'd1);
    check("ovf lo", bus4.lo_out, 32'h8000_0000);
    check("ovf hi", bus4.hi_out, 32'd0);
    check("ovf no dbz", 32'(bus4.div_by_zero), 32'd0);
    bus4.start = 1; bus4.is_signed = 0; bus4.op_a = 32'd9; bus4.op_b = 32'd3;
    ticks(1);
    bus4.start = 0;
    check("b2b busy", 32'(bus4.busy), 32'd1);
    check("b2b done low", 32'(bus4.done), 32'd0);
    ticks(5);
    check("b2b done", 32'(bus4.done), 32'd1);
    check("b2b lo", bus4.lo_out, 32'd3);
    check("b2b hi", bus4.hi_out, 32'd0);
    ticks(1);

    // start and MTLO during WAIT are ignored
    bus4.start = 1; bus4.is_signed = 0; bus4.op_a = 32'd20; bus4.op_b = 32'd6;
    ticks(1);
    bus4.start = 0;
    ticks(1);
    bus4.start = 1; bus4.op_a = 32'd100; bus4.op_b = 32'd1;
    bus4.lo_we = 1; bus4.wr_data = 32'hDEAD;
    ticks(1);
    bus4.start = 0; bus4.lo_we = 0;
    check("wait dividend held", bus4.dv_dividend, 32'd20);
    check("wait lo untouched", bus4.lo_out, 32'd3);
    ticks(3);
    check("wait done", 32'(bus4.done), 32'd1);
    check("wait lo", bus4.lo_out, 32'd3);
    check("wait hi", bus4.hi_out, 32'd2);
    ticks(1);
    check("wait idle after", 32'(bus4.done), 32'd0);

    // Same-cycle start and MTHI in IDLE: division wins
    bus0.start = 1; bus0.is_signed = 0; bus0.op_a = 32'd50; bus0.op_b = 32'd8;
    bus0.hi_we = 1; bus0.wr_data = 32'h99;
    ticks(1);
    bus0.start = 0; bus0.hi_we = 0;
    check("drop hi during N+1", bus0.hi_out, 32'h11);
    ticks(1);
    check("drop done", 32'(bus0.done), 32'd1);
    check("drop hi", bus0.hi_out, 32'd2);
    check("drop lo", bus0.lo_out, 32'd6);
    // MTHI in the DONE cycle lands at the DONE edge
    bus0.hi_we = 1; bus0.wr_data = 32'h55;
    ticks(1);
    bus0.hi_we = 0;
    check("done mthi", bus0.hi_out, 32'h55);
    check("done mthi lo kept", bus0.lo_out, 32'd6);

    // Asynchronous reset in the middle of WAIT
    bus4.start = 1; bus4.is_signed = 0; bus4.op_a = 32'd9; bus4.op_b = 32'd3;
    ticks(1);
    bus4.start = 0;
    ticks(1);
    check("pre-rst busy", 32'(bus4.busy), 32'd1);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst busy", 32'(bus4.busy), 32'd0);
    check("arst done", 32'(bus4.done), 32'd0);
    check("arst hi", bus4.hi_out, 32'd0);
    check("arst lo", bus4.lo_out, 32'd0);
    check("arst dv_valid", 32'(bus4.dv_valid), 32'd0);
    check("arst dv_dividend", bus4.dv_dividend, 32'd0);
    check("arst dv_divisor", bus4.dv_divisor, 32'd0);
    check("arst hi0", bus0.hi_out, 32'd0);
    ticks(1);
    #4;
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      ticks(1);
      check("no spurious done", 32'(bus4.done), 32'd0);
      check("no spurious busy", 32'(bus4.busy), 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/div_ctrl.md
Name: div_ctrl

Overview:
Sequencer for the 32-bit restoring divider datapath (pipeline depth configurable by its stage mask). It accepts DIV/DIVU requests from the execute stage and converts signed operands to magnitudes. It holds the divider inputs stable for the datapath latency, applies sign correction, and owns the architectural HI/LO registers, including MTHI/MTLO writes and the busy stall for MFHI/MFLO.

Parameters:
BITS, 32, operand/result width
LATENCY, 0, register stages in the divider datapath (popcount of its stage mask); 0 = fully combinational
CNT_W, 6, width of the wait counter; must hold LATENCY

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
start  in  1  request a division this cycle
is_signed  in  1  1 = DIV, 0 = DIVU; sampled with start
op_a  in  BITS  dividend; sampled with start
op_b  in  BITS  divisor; sampled with start
hi_we  in  1  MTHI write strobe
lo_we  in  1  MTLO write strobe
wr_data  in  BITS  MTHI/MTLO data
busy  out  1  division in flight; execute stage stalls MFHI/MFLO/DIV
done  out  1  one-cycle pulse, HI/LO updated this cycle
div_by_zero  out  1  qualifies done; divisor was 0
hi_out  out  BITS  architectural HI (remainder)
lo_out  out  BITS  architectural LO (quotient)
dv_dividend  out  BITS  to divider dividend
dv_divisor  out  BITS  to divider divisor
dv_valid  out  1  to divider valid
dv_quotient  in  BITS  from divider quotient output
dv_remainder  in  BITS  from divider remainder output

Behaviour:
- Reset (asynchronous, reset==0): state IDLE. All outputs and internal registers are 0: busy, done, div_by_zero, hi_out, lo_out, dv_*, counter, and the sign flags.
- FSM states:
  - IDLE and DONE accept work. done=1 only in DONE.
  - WAIT: busy=1.
- start in IDLE/DONE at cycle N, op_b!=0:
  - Register the magnitudes |op_a| and |op_b| (raw values when is_signed=0).
  - Register neg_q = is_signed & (a[31]^b[31]) and neg_r = is_signed & a[31].
  - Load counter=LATENCY and go to WAIT.
- WAIT:
  - dv_dividend/dv_divisor are driven from the registered magnitudes and held stable throughout WAIT.
  - dv_valid=1 only in the first WAIT cycle.
  - counter decrements each cycle. When counter==0, sample dv_quotient/dv_remainder.
  - lo_out <= neg_q ? -q : q; hi_out <= neg_r ? -r : r. Go to DONE.
- Latency: busy is high in cycles N+1..N+1+LATENCY. done is high in cycle N+2+LATENCY, with new HI/LO visible in that cycle.
- DONE lasts one cycle: start there is accepted (back-to-back), else return to IDLE.
- start during WAIT: ignored (no queueing); the issuer must honour busy.
- Divide by zero (op_b==0 at start): no WAIT. Next cycle is DONE with div_by_zero=1 and hi_out/lo_out unchanged.
- Signed overflow -2^31 / -1: magnitudes wrap naturally, giving lo_out=0x80000000, hi_out=0. No flag.
- Negation is two's complement modulo 2^BITS; |0x80000000| = 0x80000000.
- MTHI/MTLO:
  - hi_we/lo_we update hi_out/lo_out at the clock edge when not in WAIT.
  - They are ignored during WAIT.
  - start in the same cycle wins; the write is dropped.
  - In DONE, a write in the same cycle overrides nothing: the division result was written on entry to DONE, and the write applies at the DONE edge.
- Reset asserted mid-operation: abort immediately to the reset values. The divider pipeline contents are discarded because dv_valid is 0.

Decomposition:
- A shared package holds:
  - the FSM state encoding (IDLE, WAIT, DONE)
  - BITS default
  - the helper function abs/negate for BITS-wide two's complement
  - the LATENCY derivation function (popcount of the divider stage mask), so the top level passes a consistent value to both blocks
- One natural sub-module: div_sign_fix (combinational result negation). It is reused by the multiplier controller.
- The divider itself is instantiated beside div_ctrl by the parent, not inside it.

Test Plan:
- DIVU, LATENCY=0: start op_a=100, op_b=7 -> done at N+2, lo_out=14, hi_out=2, busy high for one cycle only.
- DIV, LATENCY=4: start op_a=-7 (0xFFFFFFF9), op_b=2 -> done at N+6, lo_out=0xFFFFFFFD (-3), hi_out=0xFFFFFFFF (-1).
- Divide by zero: hi_out=0x11, lo_out=0x22 preloaded via MTHI/MTLO, then start op_b=0 -> done+div_by_zero at N+1, HI/LO still 0x11/0x22.
- Overflow plus back-to-back:
  - DIV 0x80000000 / 0xFFFFFFFF -> lo_out=0x80000000, hi_out=0.
  - start again in the done cycle with DIVU 9/3 -> second done LATENCY+2 cycles later, lo_out=3, hi_out=0.
- Busy rules: start and lo_we pulsed during WAIT -> both ignored, result unchanged. Same-cycle start and hi_we in IDLE -> division runs, write dropped.
- Reset: reset driven to 0 mid-WAIT, asynchronous to clock -> all outputs 0 immediately. After release, no spurious done.
